// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable, syncs, blanking, DrawX/DrawY, line/frame strobes.
// Decoded outputs register alongside the counters with zero relative latency; free-running, no backpressure.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CLK_DIV   = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        pix_en,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  X_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0]  Y_VIS    = 10'(V_VISIBLE);
   // 11-bit bounds so a sync region ending exactly at 1024 still compares correctly
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
         $error("vga_timing_gen: totals must fit in 10 bits and CLK_DIV must be >= 1");
      end
   endgenerate

   logic [DIV_W-1:0] div;
   logic             x_wrap;
   logic             y_wrap;
   logic [9:0]       next_x;
   logic [9:0]       next_y;

   function automatic logic hs_of(input logic [9:0] x);
      return !(({1'b0, x} >= HS_START) && ({1'b0, x} < HS_END));
   endfunction

   function automatic logic vs_of(input logic [9:0] y);
      return !(({1'b0, y} >= VS_START) && ({1'b0, y} < VS_END));
   endfunction

   assign pix_en     = (div == DIV_LAST);
   assign VGA_SYNC_N = 1'b0;

   always_comb begin
      x_wrap = (DrawX == X_LAST);
      y_wrap = (DrawY == Y_LAST);
      next_x = x_wrap ? 10'd0 : DrawX + 10'd1;
      next_y = DrawY;
      if (x_wrap) begin
         next_y = y_wrap ? 10'd0 : DrawY + 10'd1;
      end
   end

   // Decodes are taken from next_x/next_y so they land in the same cycle as the counters.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div         <= '0;
         DrawX       <= 10'd0;
         DrawY       <= 10'd0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         div         <= pix_en ? '0 : div + 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_en) begin
            DrawX       <= next_x;
            DrawY       <= next_y;
            VGA_HS      <= hs_of(next_x);
            VGA_VS      <= vs_of(next_y);
            VGA_BLANK_N <= (next_x < X_VIS) && (next_y < Y_VIS);
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
            if (x_wrap && y_wrap) begin
               frame_count <= frame_count + 16'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480/div2, tiny/div1, tiny/div3)
// checked every cycle against a closed-form model of elapsed clocks since reset.
module tb_vga_timing_gen;
   typedef struct packed {
      logic        pe;
      logic        hs;
      logic        vs;
      logic        bn;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   logic Clk = 1'b0;
   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   always #5 Clk = ~Clk;

   logic a_pe, a_hs, a_vs, a_bn, a_sn, a_ls, a_fs;
   logic b_pe, b_hs, b_vs, b_bn, b_sn, b_ls, b_fs;
   logic c_pe, c_hs, c_vs, c_bn, c_sn, c_ls, c_fs;
   logic [9:0]  a_x, a_y, b_x, b_y, c_x, c_y;
   logic [15:0] a_fc, b_fc, c_fc;

   vga_timing_gen dut_a (
      .Clk(Clk), .Reset(rst_a), .pix_en(a_pe), .VGA_HS(a_hs), .VGA_VS(a_vs),
      .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn), .DrawX(a_x), .DrawY(a_y),
      .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));

   vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)) dut_b (
      .Clk(Clk), .Reset(rst_b), .pix_en(b_pe), .VGA_HS(b_hs), .VGA_VS(b_vs),
      .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .DrawX(b_x), .DrawY(b_y),
      .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));

   vga_timing_gen #(.H_VISIBLE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(2), .CLK_DIV(3)) dut_c (
      .Clk(Clk), .Reset(rst_c), .pix_en(c_pe), .VGA_HS(c_hs), .VGA_VS(c_vs),
      .VGA_BLANK_N(c_bn), .VGA_SYNC_N(c_sn), .DrawX(c_x), .DrawY(c_y),
      .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, expv, $time);
      end
   endtask

   // Everything follows from t = clocks since the last reset edge: p = t/d pixels have elapsed.
   function automatic exp_t ref_model(input int t, input int d,
                                      input int hv, input int hf, input int hsw, input int hb,
                                      input int vv, input int vf, input int vsw, input int vb);
      exp_t e;
      int ht = hv + hf + hsw + hb;
      int vt = vv + vf + vsw + vb;
      int p  = t / d;
      int x  = p % ht;
      int y  = (p / ht) % vt;
      bit just_advanced = (p > 0) && (t % d == 0);
      e.pe = (t % d == d - 1);
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.hs = !(x >= hv + hf && x < hv + hf + hsw);
      e.vs = !(y >= vv + vf && y < vv + vf + vsw);
      e.bn = (x < hv) && (y < vv);
      e.ls = just_advanced && (x == 0);
      e.fs = just_advanced && (x == 0) && (y == 0);
      e.fc = 16'(p / (ht * vt));
      return e;
   endfunction

   task automatic check_dut(input string n, input exp_t obs, input exp_t e, input logic sn);
      check({n, ".pix_en"},      obs.pe, e.pe);
      check({n, ".hs"},          obs.hs, e.hs);
      check({n, ".vs"},          obs.vs, e.vs);
      check({n, ".blank_n"},     obs.bn, e.bn);
      check({n, ".x"},           obs.x,  e.x);
      check({n, ".y"},           obs.y,  e.y);
      check({n, ".line_start"},  obs.ls, e.ls);
      check({n, ".frame_start"}, obs.fs, e.fs);
      check({n, ".frame_count"}, obs.fc, e.fc);
      check({n, ".sync_n"},      sn,     0);
   endtask

   int t_a = 0, t_b = 0, t_c = 0;
   bit val_a = 0, val_b = 0, val_c = 0;

   always @(posedge Clk) begin
      t_a <= rst_a ? 0 : t_a + 1;
      t_b <= rst_b ? 0 : t_b + 1;
      t_c <= rst_c ? 0 : t_c + 1;
      val_a <= val_a | rst_a;
      val_b <= val_b | rst_b;
      val_c <= val_c | rst_c;
   end

   always @(negedge Clk) begin
      if (val_a) check_dut("a", {a_pe, a_hs, a_vs, a_bn, a_x, a_y, a_ls, a_fs, a_fc},
                           ref_model(t_a, 2, 640, 16, 96, 48, 480, 10, 2, 33), a_sn);
      if (val_b) check_dut("b", {b_pe, b_hs, b_vs, b_bn, b_x, b_y, b_ls, b_fs, b_fc},
                           ref_model(t_b, 1, 8, 2, 2, 2, 4, 1, 1, 1), b_sn);
      if (val_c) check_dut("c", {c_pe, c_hs, c_vs, c_bn, c_x, c_y, c_ls, c_fs, c_fc},
                           ref_model(t_c, 3, 5, 1, 2, 1, 3, 1, 1, 2), c_sn);
   end

   int  hs_low = 0;
   bit  line_done = 0, seen_blank = 0, found = 0;
   int  last_fs = -1;
   int  cnt_a = 0, cnt_b = 0, cnt_c = 0;

   initial begin
      repeat (3) @(negedge Clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Free run: first full line of the 640x480 instance and frame spacing of the tiny one.
      for (int c = 1; c <= 4000; c++) begin
         @(negedge Clk);
         if (!line_done && !a_hs) hs_low++;
         if (!line_done && a_ls) begin
            line_done = 1;
            check("a.hs_low_clks", hs_low, 192);
            check("a.line_start_y", a_y, 1);
         end
         if (!seen_blank && !a_bn) begin
            seen_blank = 1;
            check("a.blank_fall_x", a_x, 640);
         end
         if (b_fs) begin
            if (last_fs < 0) check("b.first_frame_clk", c, 98);
            else             check("b.frame_period", c - last_fs, 98);
            last_fs = c;
         end
      end
      check("a.line_seen", line_done, 1);
      check("a.blank_seen", seen_blank, 1);

      // Reset while both syncs are low on the tiny instance.
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge Clk);
         if (b_x == 10'd10 && b_y == 10'd5) found = 1;
      end
      check("b.sync_point_reached", found, 1);
      check("b.hs_low_before_reset", b_hs, 0);
      check("b.vs_low_before_reset", b_vs, 0);
      rst_b = 1'b1;
      @(negedge Clk);
      check("b.rst_hs", b_hs, 1);
      check("b.rst_vs", b_vs, 1);
      check("b.rst_x", b_x, 0);
      check("b.rst_y", b_y, 0);
      check("b.rst_fc", b_fc, 0);
      check("b.rst_ls", b_ls, 0);
      check("b.rst_fs", b_fs, 0);
      rst_b = 1'b0;

      // Random reset pulses of random length on every instance.
      for (int c = 0; c < 8000; c++) begin
         @(negedge Clk);
         if (cnt_a > 0) cnt_a--; else if ($urandom_range(0, 599) == 0) cnt_a = $urandom_range(1, 4);
         if (cnt_b > 0) cnt_b--; else if ($urandom_range(0, 149) == 0) cnt_b = $urandom_range(1, 4);
         if (cnt_c > 0) cnt_c--; else if ($urandom_range(0, 249) == 0) cnt_c = $urandom_range(1, 4);
         rst_a = (cnt_a > 0);
         rst_b = (cnt_b > 0);
         rst_c = (cnt_c > 0);
      end
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      repeat (4) @(negedge Clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing: horizontal and vertical sync, blanking, and the current pixel coordinates DrawX and DrawY.
- These coordinates are what the colour mapper and the sprite, arrow and receptor logic consume.
- It also produces a pixel-rate enable, plus line-start and frame-start strobes, so game logic (arrow scroll, receptor state) can update once per frame.
- Sits at the top level between the system clock and the VGA DAC pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel (≥1); 50 MHz / 2 = 25 MHz pixel rate

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- pix_en  output  1  one-Clk pulse per pixel period; counters advance on it
- VGA_HS  output  1  horizontal sync, active low
- VGA_VS  output  1  vertical sync, active low
- VGA_BLANK_N  output  1  high while in the visible region
- VGA_SYNC_N  output  1  tied 0 (no sync-on-green)
- DrawX  output  10  horizontal pixel counter, 0..H_TOTAL-1
- DrawY  output  10  vertical line counter, 0..V_TOTAL-1
- line_start  output  1  one-Clk pulse when DrawX becomes 0
- frame_start  output  1  one-Clk pulse when (DrawX,DrawY) becomes (0,0)
- frame_count  output  16  frames completed since reset, wraps modulo 2^16

Behaviour:
- Definitions: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must fit in 10 bits; an elaboration-time check enforces this.
- Clock interface: one clock domain (Clk). Reset is synchronous and active-high; it is sampled only on the rising edge of Clk.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div == CLK_DIV-1). With CLK_DIV=1, pix_en is 1 every cycle after reset.
- Counters: advance only on an edge where pix_en=1.
  - DrawX increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, DrawY increments and wraps from V_TOTAL-1 to 0.
  - Both hold when pix_en=0.
- Decoded outputs are registered, updated on the same edge as the counters, and always consistent with the DrawX/DrawY values presented in the same cycle (zero relative latency):
  - VGA_HS = 0 iff H_VISIBLE+H_FP ≤ DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
  - VGA_VS = 0 iff V_VISIBLE+V_FP ≤ DrawY < V_VISIBLE+V_FP+V_SYNC (490..491).
  - VGA_BLANK_N = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- Strobes: line_start and frame_start are 1 for exactly the single Clk cycle immediately following the advancing edge that produced DrawX=0 (respectively DrawX=0 and DrawY=0); otherwise 0.
- frame_count increments on the same edge that asserts frame_start. Wrap 65535→0 is silent.
- Reset values on the edge where Reset=1:
  - div=0, DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=1, frame_count=0.
  - line_start=0, frame_start=0, pix_en=0 (if CLK_DIV>1).
  - No strobe fires for the reset-forced (0,0); the first frame_start fires at the first natural wrap.
- Reset mid-line or mid-sync: all state returns to the reset values on that edge. Sync pulses may be truncated; this is acceptable.
- Reset held: outputs stay at their reset values; counters do not advance.
- Simultaneous DrawX and DrawY wrap: frame_start and line_start assert in the same cycle.

Test Plan:
- Reset, CLK_DIV=2 -> pix_en toggles 0,1,0,1…; DrawX advances 0→1 two Clk cycles after reset release; all outputs at their reset values while Reset=1.
- Run one full line -> VGA_HS low for exactly 96 pixel periods starting at DrawX=656; VGA_BLANK_N falls at DrawX=640; line_start pulses once as DrawX wraps 799→0 and DrawY goes 0→1.
- Run one full frame -> VGA_VS low for DrawY=490..491 only (1600 pixel periods); frame_start pulses once at the first (0,0) after 420000 pixel periods; frame_count=1.
- Assert Reset at DrawX=700, DrawY=491 (both syncs low) -> next cycle VGA_HS=VGA_VS=1, DrawX=DrawY=0, frame_count=0, no strobe.
- Force frame_count to 65535 (or run/preload) -> next frame_start sets frame_count=0.
- CLK_DIV=1 with small timing parameters (H: 8,2,2,2; V: 4,1,1,1) -> pix_en constantly 1, H_TOTAL=14, V_TOTAL=7; frame_start every 98 Clk cycles.
